// File: rtl/crt_sync_gen.sv
// Free-running 640x480 CRT timing generator. A clock divider produces the pixel
// tick, and h/v counters drive registered sync, blanking and address outputs.
module crt_sync_gen #(
  parameter int CLK_DIV = 4,
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic [9:0] col_addr,
  output logic [8:0] row_addr,
  output logic       hs,
  output logic       vs,
  output logic       rdn,
  output logic       fresh,
  output logic       px_tick
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);

  localparam logic [9:0] H_VIS    = 10'd640;
  localparam logic [9:0] H_SYNC_S = 10'd656;
  localparam logic [9:0] H_SYNC_E = 10'd751;
  localparam logic [9:0] V_VIS    = 10'd480;
  localparam logic [9:0] V_SYNC_S = 10'd490;
  localparam logic [9:0] V_SYNC_E = 10'd491;

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [9:0]    h_q, h_d;
  logic [9:0]    v_q, v_d;
  logic [8:0]    row_q, row_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          rdn_q, rdn_d;
  logic          fresh_q, fresh_d;
  logic          px_tick_q, px_tick_d;
  logic          tick_now;

  always_comb begin
    tick_now  = (div_cnt_q == DIV_LAST);
    div_cnt_d = tick_now ? '0 : div_cnt_q + 1'b1;
    h_d       = h_q;
    v_d       = v_q;
    if (tick_now) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
    // Decode from the next-state counters so every output lines up with col/row.
    px_tick_d = (div_cnt_d == DIV_LAST);
    row_d     = (v_d < V_VIS) ? v_d[8:0] : 9'd511;
    hs_d      = !((h_d >= H_SYNC_S) && (h_d <= H_SYNC_E));
    vs_d      = !((v_d >= V_SYNC_S) && (v_d <= V_SYNC_E));
    rdn_d     = !((h_d < H_VIS) && (v_d < V_VIS));
    fresh_d   = (v_d >= V_VIS);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      div_cnt_q <= '0;
      h_q       <= '0;
      v_q       <= '0;
      row_q     <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      rdn_q     <= 1'b0;
      fresh_q   <= 1'b0;
      px_tick_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      h_q       <= h_d;
      v_q       <= v_d;
      row_q     <= row_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      rdn_q     <= rdn_d;
      fresh_q   <= fresh_d;
      px_tick_q <= px_tick_d;
    end
  end

  assign col_addr = h_q;
  assign row_addr = row_q;
  assign hs       = hs_q;
  assign vs       = vs_q;
  assign rdn      = rdn_q;
  assign fresh    = fresh_q;
  assign px_tick  = px_tick_q;

endmodule
